// File: rtl/fifo_fwft_downsizer.sv
// Width-reducing read stage behind a FWFT FIFO: pops one wide word and streams its RATIO
// slices on a valid/ready port. Define FIFO_DOWNSIZER_MSB_FIRST_EN for MSB-first slice order.
module fifo_fwft_downsizer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RATIO      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH*RATIO-1:0] fifo_dout_i,
  input  logic                        fifo_empty_i,
  output logic                        fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0]       dout_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        last_o
);

  localparam int unsigned BeatW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(RATIO - 1);

  logic [RATIO-1:0][DATA_WIDTH-1:0] hold_q, hold_d;
  logic [BeatW-1:0]                 beat_q, beat_d;
  logic                             valid_q, valid_d;
  logic                             acc, done, pop;

  assign acc  = valid_q & ready_i;
  assign done = acc & (beat_q == LastBeat);
  // Refill in the same cycle the last slice leaves so words stream without bubbles.
  assign pop  = ~rst & ~fifo_empty_i & (~valid_q | done);

  always_comb begin
    hold_d  = hold_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    if (pop) begin
      hold_d  = fifo_dout_i;
      beat_d  = '0;
      valid_d = 1'b1;
    end else if (done) begin
      beat_d  = '0;
      valid_d = 1'b0;
    end else if (acc) begin
      beat_d  = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
  assign dout_o = hold_q[LastBeat - beat_q];
`else
  assign dout_o = hold_q[beat_q];
`endif

  assign fifo_rd_en_o = pop;
  assign valid_o      = valid_q;
  assign last_o       = valid_q & (beat_q == LastBeat);

endmodule

// File: tb/tb_fifo_fwft_downsizer.sv
// Directed vector table for the downsizer, followed by a randomized scoreboard run.
module tb_fifo_fwft_downsizer;

  localparam logic [31:0] W1 = 32'h4433_2211;
  localparam logic [31:0] W2 = 32'h8877_6655;
  localparam logic [31:0] W3 = 32'hDDCC_BBAA;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  dout;
  logic        valid;
  logic        ready;
  logic        last;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_fwft_downsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_dout_i (fifo_dout),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_en_o(fifo_rd_en),
    .dout_o      (dout),
    .valid_o     (valid),
    .ready_i     (ready),
    .last_o      (last)
  );

  // Expected slice b of a held word, in presentation order.
  function automatic logic [7:0] slice(input logic [31:0] w, input int b);
`ifdef FIFO_DOWNSIZER_MSB_FIRST_EN
    return w[(3-b)*8 +: 8];
`else
    return w[b*8 +: 8];
`endif
  endfunction

  typedef struct {
    logic        rst;
    logic        empty;
    logic [31:0] din;
    logic        ready;
    logic        exp_rd;
    logic        exp_valid;
    logic        exp_last;
    logic [31:0] exp_word;
    int          exp_beat;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       last;
  } slice_t;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  vec_t   vt[$];
  slice_t sb[$];

  task automatic add(input logic r, input logic e, input logic [31:0] d, input logic rdy,
                     input logic xrd, input logic xv, input logic xl, input logic [31:0] xw,
                     input int xb);
    vec_t v;
    v.rst = r; v.empty = e; v.din = d; v.ready = rdy;
    v.exp_rd = xrd; v.exp_valid = xv; v.exp_last = xl; v.exp_word = xw; v.exp_beat = xb;
    vt.push_back(v);
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; ready = 1'b1;

    //   rst empty din  rdy | rd valid last word beat
    // reset, including a non-empty FIFO during reset
    add(1, 0, W1, 1,  0, 0, 0, 32'h0, 0);
    add(1, 1, W1, 1,  0, 0, 0, 32'h0, 0);
    add(0, 1, W1, 1,  0, 0, 0, 32'h0, 0);
    // single word
    add(0, 0, W1, 1,  1, 0, 0, 32'h0, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 1);
    add(0, 1, W1, 1,  0, 1, 0, W1, 2);
    add(0, 1, W1, 1,  0, 1, 1, W1, 3);
    add(0, 1, W1, 1,  0, 0, 0, W1, 0);
    // back-to-back, second pop on the last-slice accept
    add(0, 0, W1, 1,  1, 0, 0, W1, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 1);
    add(0, 1, W1, 1,  0, 1, 0, W1, 2);
    add(0, 0, W2, 1,  1, 1, 1, W1, 3);
    add(0, 1, W2, 1,  0, 1, 0, W2, 0);
    add(0, 1, W2, 1,  0, 1, 0, W2, 1);
    add(0, 1, W2, 1,  0, 1, 0, W2, 2);
    add(0, 1, W2, 1,  0, 1, 1, W2, 3);
    add(0, 1, W2, 1,  0, 0, 0, W2, 0);
    // backpressure with a non-empty FIFO
    add(0, 0, W1, 1,  1, 0, 0, W2, 0);
    add(0, 0, W2, 1,  0, 1, 0, W1, 0);
    add(0, 0, W2, 0,  0, 1, 0, W1, 1);
    add(0, 0, W2, 0,  0, 1, 0, W1, 1);
    add(0, 0, W2, 0,  0, 1, 0, W1, 1);
    add(0, 1, W2, 1,  0, 1, 0, W1, 1);
    add(0, 1, W2, 1,  0, 1, 0, W1, 2);
    add(0, 0, W2, 0,  0, 1, 1, W1, 3);
    add(0, 0, W2, 1,  1, 1, 1, W1, 3);
    add(0, 1, W2, 1,  0, 1, 0, W2, 0);
    add(0, 1, W2, 1,  0, 1, 0, W2, 1);
    add(0, 1, W2, 1,  0, 1, 0, W2, 2);
    add(0, 1, W2, 1,  0, 1, 1, W2, 3);
    add(0, 1, W2, 1,  0, 0, 0, W2, 0);
    // reset mid-word after the second slice is accepted
    add(0, 0, W3, 1,  1, 0, 0, W2, 0);
    add(0, 1, W3, 1,  0, 1, 0, W3, 0);
    add(0, 1, W3, 1,  0, 1, 0, W3, 1);
    add(1, 0, W1, 1,  0, 1, 0, W3, 2);
    add(0, 1, W1, 1,  0, 0, 0, 32'h0, 0);
    add(0, 0, W1, 1,  1, 0, 0, 32'h0, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 0);
    add(0, 1, W1, 1,  0, 1, 0, W1, 1);
    add(0, 1, W1, 1,  0, 1, 0, W1, 2);
    add(0, 1, W1, 1,  0, 1, 1, W1, 3);
    add(0, 1, W1, 1,  0, 0, 0, W1, 0);

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; fifo_empty = vt[i].empty; fifo_dout = vt[i].din; ready = vt[i].ready;
      #1;
      check("rd_en", i, 32'(fifo_rd_en), 32'(vt[i].exp_rd));
      check("valid", i, 32'(valid), 32'(vt[i].exp_valid));
      check("last",  i, 32'(last), 32'(vt[i].exp_last));
      check("dout",  i, 32'(dout), 32'(slice(vt[i].exp_word, vt[i].exp_beat)));
    end

    // Randomized run against a slice scoreboard.
    @(negedge clk);
    rst = 1'b1; fifo_empty = 1'b1; ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      fifo_empty = ($urandom_range(0, 2) == 0);
      fifo_dout  = $urandom;
      ready      = ($urandom_range(0, 3) != 0);
      #1;
      if (fifo_rd_en && fifo_empty) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_en_while_empty cycle %0d: got rd_en=1 expected 0", c);
      end
      if (valid && ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rnd_unexpected cycle %0d: got slice %0h expected none", c, dout);
        end else begin
          slice_t s;
          s = sb.pop_front();
          check("rnd_dout", c, 32'(dout), 32'(s.d));
          check("rnd_last", c, 32'(last), 32'(s.last));
        end
      end
      if (fifo_rd_en && !fifo_empty)
        for (int b = 0; b < 4; b++) begin
          slice_t s;
          s.d = slice(fifo_dout, b);
          s.last = (b == 3);
          sb.push_back(s);
        end
    end
    // At most one word may still be in flight at the end.
    check("rnd_leftover_le4", 0, 32'(sb.size() <= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
